// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle shared by the two-port arbiter (master side) and the peripheral fabric (slave side).
interface apb_master_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [3:0]        PSTRB;
  logic [2:0]        PPROT;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-port round-robin APB master: arbitrates command ports, runs IDLE/SETUP/ACCESS on the bus and
// returns read data / error to the issuing port. All outputs registered, synchronous reset.
module apb_master_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [7:0]          req_strb,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  apb_master_arbiter_if.master apb
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e            state_q;
  logic              rr_ptr_q;
  logic              gnt_q;
  logic [CntW-1:0]   cnt_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [3:0]        pstrb_q;

  logic              gnt;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [3:0]        sel_strb;

  // Contested cycles go to rr_ptr; otherwise the lone valid port wins.
  always_comb begin
    gnt       = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
    sel_write = gnt ? req_write[1] : req_write[0];
    sel_addr  = gnt ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = gnt ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    sel_strb  = gnt ? req_strb[7:4] : req_strb[3:0];
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      rr_ptr_q  <= 1'b0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state_q)
        StIdle: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          if (|req_valid) begin
            gnt_q     <= gnt;
            rr_ptr_q  <= ~gnt;
            req_ready <= gnt ? 2'b10 : 2'b01;
            pwrite_q  <= sel_write;
            paddr_q   <= sel_addr;
            pwdata_q  <= sel_wdata;
            pstrb_q   <= sel_write ? sel_strb : 4'h0;
            psel_q    <= 1'b1;
            state_q   <= StSetup;
          end
        end
        StSetup: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StAccess;
        end
        StAccess: begin
          if (apb.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_valid <= gnt_q ? 2'b10 : 2'b01;
            rsp_rdata <= pwrite_q ? '0 : apb.PRDATA;
            rsp_err   <= apb.PSLVERR;
            state_q   <= StIdle;
          end else if (cnt_q == CntLast) begin
            // Slave never answered: abort and report an error to the issuer.
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_valid <= gnt_q ? 2'b10 : 2'b01;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PPROT   = 3'b000;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus a randomized run against a transaction-level
// model of round-robin grants, APB setup fields and per-port responses.
module tb_apb_master_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [7:0]    req_strb;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Slave behaviour knobs.
  int          slv_wait  = 0;
  bit          slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;
  bit          slv_rand  = 1'b0;
  int          acc_n     = 0;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb_bus ();

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_strb  (req_strb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb_bus)
  );

  // APB slave: PREADY rises after slv_wait low ACCESS cycles; PSLVERR driven continuously.
  initial begin
    apb_bus.PREADY  = 1'b0;
    apb_bus.PSLVERR = 1'b0;
    apb_bus.PRDATA  = '0;
    forever begin
      @(negedge clk);
      if (slv_rand && apb_bus.PSEL && !apb_bus.PENABLE) begin
        slv_wait  = int'($urandom_range(0, 3));
        slv_err   = bit'($urandom_range(0, 1));
        slv_rdata = $urandom;
      end
      if (apb_bus.PSEL && apb_bus.PENABLE) acc_n++;
      else acc_n = 0;
      apb_bus.PREADY  = apb_bus.PSEL && apb_bus.PENABLE && (acc_n > slv_wait);
      apb_bus.PSLVERR = slv_err;
      apb_bus.PRDATA  = slv_rdata;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    req_write[p]        = w;
    req_addr[p*32 +: 32]  = a;
    req_wdata[p*32 +: 32] = d;
    req_strb[p*4 +: 4]    = s;
  endtask

  // Drives one command on port p and records what came back; no checking here.
  task automatic run_xfer(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int rdy_cyc, output int rsp_cyc,
                          output logic [1:0] rsp_seen, output logic [31:0] rdata, output logic err);
    int cyc;
    set_cmd(p, w, a, d, s);
    req_valid[p] = 1'b1;
    rdy_cyc = -1; rsp_cyc = -1; rsp_seen = 2'b00; rdata = '0; err = 1'b0; cyc = 0;
    while (rsp_cyc < 0 && cyc < 100) begin
      tick;
      cyc++;
      if (rdy_cyc < 0 && req_ready != 2'b00) begin
        rdy_cyc = cyc;
        req_valid[p] = 1'b0;
      end
      if (rsp_valid != 2'b00) begin
        rsp_cyc = cyc; rsp_seen = rsp_valid; rdata = rsp_rdata; err = rsp_err;
      end
    end
    req_valid[p] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++;
    if ({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000",
                         {apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE});
    end
    n_cmp++;
    if ({apb_bus.PADDR, apb_bus.PWDATA, apb_bus.PSTRB, apb_bus.PPROT} !== 71'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h %h %h %h expected all 0", apb_bus.PADDR,
                         apb_bus.PWDATA, apb_bus.PSTRB, apb_bus.PPROT);
    end
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 37'h0) begin
      n_fail++; $display("FAIL reset_req_rsp: got %b %b %h %b expected all 0", req_ready,
                         rsp_valid, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_single_write;
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h1234_5678;
    set_cmd(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    req_valid = 2'b01;
    tick;  // cycle 1
    n_cmp++;
    if ({req_ready, apb_bus.PSEL, apb_bus.PENABLE} !== 4'b0110) begin
      n_fail++; $display("FAIL wr_cycle1_ctrl: got %b expected 0110",
                         {req_ready, apb_bus.PSEL, apb_bus.PENABLE});
    end
    n_cmp++;
    if ({apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA, apb_bus.PSTRB} !==
        {1'b1, 32'h10, 32'hA5A5_0001, 4'hF}) begin
      n_fail++; $display("FAIL wr_setup_fields: got %b %h %h %h expected 1 10 a5a50001 f",
                         apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA, apb_bus.PSTRB);
    end
    req_valid = 2'b00;
    tick;  // cycle 2
    n_cmp++;
    if ({req_ready, apb_bus.PSEL, apb_bus.PENABLE, rsp_valid} !== 6'b001100) begin
      n_fail++; $display("FAIL wr_cycle2_access: got %b expected 001100",
                         {req_ready, apb_bus.PSEL, apb_bus.PENABLE, rsp_valid});
    end
    tick;  // cycle 3
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata, apb_bus.PSEL} !== {2'b01, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL wr_cycle3_rsp: got %b %b %h %b expected 01 0 0 0", rsp_valid,
                         rsp_err, rsp_rdata, apb_bus.PSEL);
    end
  endtask

  task automatic test_read_wait;
    slv_wait = 3; slv_err = 1'b0; slv_rdata = 32'hDEAD_BEEF;
    set_cmd(1, 1'b0, 32'h20, 32'h5555_AAAA, 4'hF);
    req_valid = 2'b10;
    tick;
    n_cmp++;
    if ({req_ready, apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PSTRB, apb_bus.PADDR}
        !== {2'b10, 3'b100, 4'h0, 32'h20}) begin
      n_fail++; $display("FAIL rd_setup: got %b %b%b%b %h %h expected 10 100 0 20", req_ready,
                         apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PSTRB,
                         apb_bus.PADDR);
    end
    req_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++;
      if ({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, rsp_valid} !== {2'b11, 32'h20, 2'b00})
      begin
        n_fail++; $display("FAIL rd_access_stable[%0d]: got %b%b %h %b expected 11 20 00", k,
                           apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PADDR, rsp_valid);
      end
    end
    tick;
    n_cmp++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_rsp: got %b %b %h expected 10 0 deadbeef", rsp_valid, rsp_err,
                         rsp_rdata);
    end
  endtask

  task automatic test_pslverr;
    int rc, sc; logic [1:0] seen; logic [31:0] rd; logic e;
    slv_wait = 1; slv_err = 1'b1; slv_rdata = 32'hCAFE_F00D;
    run_xfer(0, 1'b1, 32'h44, 32'h0000_0044, 4'h3, rc, sc, seen, rd, e);
    n_cmp++;
    if ({rc, sc, seen, e, rd} !== {32'd1, 32'd4, 2'b01, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL slverr_write: got rdy@%0d rsp@%0d %b err=%b rdata=%h expected 1 4 01 1 0",
                         rc, sc, seen, e, rd);
    end
    slv_err = 1'b0; slv_rdata = 32'h1357_9BDF;
    run_xfer(1, 1'b0, 32'h48, 32'h0, 4'h0, rc, sc, seen, rd, e);
    n_cmp++;
    if ({sc, seen, e, rd} !== {32'd4, 2'b10, 1'b0, 32'h1357_9BDF}) begin
      n_fail++; $display("FAIL slverr_next_ok: got rsp@%0d %b err=%b rdata=%h expected 4 10 0 13579bdf",
                         sc, seen, e, rd);
    end
  endtask

  task automatic test_timeout;
    int rc, sc; logic [1:0] seen; logic [31:0] rd; logic e;
    slv_wait = 1000; slv_err = 1'b0; slv_rdata = 32'hFFFF_FFFF;
    run_xfer(0, 1'b0, 32'h80, 32'h0, 4'h0, rc, sc, seen, rd, e);
    // SETUP in cycle 1, TIMEOUT ACCESS cycles, abort response the cycle after.
    n_cmp++;
    if (sc !== 2 + int'(TO)) begin
      n_fail++; $display("FAIL timeout_latency: got rsp@%0d expected %0d", sc, 2 + int'(TO));
    end
    n_cmp++;
    if ({seen, e, rd, apb_bus.PSEL, apb_bus.PENABLE} !== {2'b01, 1'b1, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL timeout_rsp: got %b err=%b rdata=%h psel=%b pen=%b expected 01 1 0 0 0",
                         seen, e, rd, apb_bus.PSEL, apb_bus.PENABLE);
    end
    tick;
    n_cmp++;
    if ({rsp_valid, apb_bus.PSEL} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_after: got %b %b expected 00 0", rsp_valid, apb_bus.PSEL);
    end
    slv_wait = 0;
  endtask

  task automatic test_back_to_back;
    bit ptr; int ngr, cyc, last; logic [31:0] a[2];
    do_reset;
    slv_wait = 0; slv_err = 1'b0;
    for (int p = 0; p < 2; p++) begin
      a[p] = $urandom;
      set_cmd(p, bit'($urandom_range(0, 1)), a[p], $urandom, 4'hF);
    end
    req_valid = 2'b11;
    ptr = 1'b0; ngr = 0; cyc = 0; last = 0;
    while (ngr < 4 && cyc < 60) begin
      tick;
      cyc++;
      if (req_ready != 2'b00) begin
        n_cmp++;
        if (req_ready !== (ptr ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL b2b_grant[%0d]: got %b expected %b", ngr, req_ready,
                             ptr ? 2'b10 : 2'b01);
        end
        n_cmp++;
        if (apb_bus.PADDR !== a[ptr]) begin
          n_fail++; $display("FAIL b2b_addr[%0d]: got %h expected %h", ngr, apb_bus.PADDR,
                             a[ptr]);
        end
        if (ngr > 0) begin
          n_cmp++;
          if (cyc - last !== 3) begin
            n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 3", ngr, cyc - last);
          end
        end
        a[ptr] = $urandom;
        set_cmd(int'(ptr), bit'($urandom_range(0, 1)), a[ptr], $urandom, 4'hF);
        ptr = ~ptr; last = cyc; ngr++;
      end
    end
    req_valid = 2'b00;
    n_cmp++;
    if (ngr !== 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 4", ngr);
    end
    repeat (4) tick;
  endtask

  task automatic test_reset_mid;
    int nrsp, cyc; logic [1:0] rdy;
    // Port 0 grant leaves the pointer at 1; reset must bring it back to 0.
    slv_wait = 1000;
    set_cmd(0, 1'b1, 32'h0000_0ABC, 32'h1111_2222, 4'hF);
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    repeat (3) tick;
    n_cmp++;
    if ({apb_bus.PSEL, apb_bus.PENABLE} !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_in_access: got %b expected 11",
                         {apb_bus.PSEL, apb_bus.PENABLE});
    end
    rst_n = 1'b0;
    tick;
    n_cmp++;
    if ({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA,
         apb_bus.PSTRB, req_ready, rsp_valid, rsp_err, rsp_rdata} !== 108'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b%b%b %h %h %h %b %b %b %h expected all 0",
                         apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR,
                         apb_bus.PWDATA, apb_bus.PSTRB, req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    rst_n = 1'b1;
    slv_wait = 0;
    nrsp = 0;
    repeat (20) begin
      tick;
      if (rsp_valid != 2'b00) nrsp++;
    end
    n_cmp++;
    if (nrsp !== 0) begin
      n_fail++; $display("FAIL rstmid_no_rsp: got %0d responses expected 0", nrsp);
    end
    set_cmd(0, 1'b0, 32'h100, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 32'h200, 32'h0, 4'h0);
    req_valid = 2'b11;
    rdy = 2'b00; cyc = 0;
    while (rdy == 2'b00 && cyc < 20) begin
      tick;
      cyc++;
      rdy = req_ready;
    end
    req_valid = 2'b00;
    n_cmp++;
    if (rdy !== 2'b01) begin
      n_fail++; $display("FAIL rstmid_port0_wins: got %b expected 01", rdy);
    end
    repeat (6) tick;
  endtask

  task automatic test_random;
    logic [1:0] drv; bit ptr, outst, out_w; int g, out_port, nx;
    bit w[2]; logic [31:0] a[2], d[2]; logic [3:0] s[2];
    do_reset;
    slv_rand = 1'b1;
    drv = 2'b00; ptr = 1'b0; outst = 1'b0; out_w = 1'b0; out_port = 0; nx = 0;
    for (int c = 0; c < 800; c++) begin
      tick;
      if (rsp_valid != 2'b00) begin
        n_cmp++;
        if (!outst || rsp_valid !== (out_port == 1 ? 2'b10 : 2'b01) || rsp_err !== slv_err ||
            rsp_rdata !== (out_w ? 32'h0 : slv_rdata)) begin
          n_fail++; $display("FAIL rnd_rsp: got %b err=%b rdata=%h expected port %0d err=%b rdata=%h",
                             rsp_valid, rsp_err, rsp_rdata, out_port, slv_err,
                             out_w ? 32'h0 : slv_rdata);
        end
        outst = 1'b0; nx++;
      end
      if (req_ready != 2'b00) begin
        g = (drv == 2'b11) ? int'(ptr) : int'(drv[1]);
        n_cmp++;
        if (outst || drv == 2'b00 || req_ready !== (g == 1 ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL rnd_grant: got %b expected port %0d (valid %b busy %b)",
                             req_ready, g, drv, outst);
        end
        n_cmp++;
        if ({apb_bus.PSEL, apb_bus.PENABLE, apb_bus.PWRITE, apb_bus.PADDR,
             w[g] ? apb_bus.PWDATA : 32'h0, apb_bus.PSTRB} !==
            {2'b10, w[g], a[g], w[g] ? d[g] : 32'h0, w[g] ? s[g] : 4'h0}) begin
          n_fail++; $display("FAIL rnd_setup: got w=%b a=%h d=%h s=%h expected w=%b a=%h d=%h s=%h",
                             apb_bus.PWRITE, apb_bus.PADDR, apb_bus.PWDATA, apb_bus.PSTRB, w[g],
                             a[g], d[g], w[g] ? s[g] : 4'h0);
        end
        ptr = (g == 0); outst = 1'b1; out_port = g; out_w = w[g]; drv[g] = 1'b0;
      end
      for (int p = 0; p < 2; p++) begin
        if (!drv[p] && $urandom_range(0, 99) < 35) begin
          w[p] = bit'($urandom_range(0, 1)); a[p] = $urandom; d[p] = $urandom;
          s[p] = 4'($urandom_range(0, 15));
          set_cmd(p, w[p], a[p], d[p], s[p]);
          drv[p] = 1'b1;
        end
      end
      req_valid = drv;
    end
    req_valid = 2'b00;
    for (int c = 0; c < 10 && outst; c++) begin
      tick;
      if (rsp_valid != 2'b00) outst = 1'b0;
    end
    n_cmp++;
    if (outst || nx < 20) begin
      n_fail++; $display("FAIL rnd_progress: got %0d completed (pending %b) expected >=20, none pending",
                         nx, outst);
    end
    slv_rand = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; req_write = 2'b00;
    req_addr = '0; req_wdata = '0; req_strb = '0;
    test_reset;
    test_single_write;
    test_read_wait;
    test_pslverr;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
